// File: rtl/midori_sbox_serial_ctrl_pkg.sv
// Shared constants and types for the serial masked Midori S-box sequencer.
// Imported by the controller top and its valid/tag pipe.
package midori_sbox_serial_ctrl_pkg;

    localparam int NIBBLES  = 16;
    localparam int SBOX_LAT = 3;
    localparam int R_W      = 36;
    localparam int RS_W     = 6;
    localparam int TAG_W    = $clog2(NIBBLES);
    localparam int CNT_W    = TAG_W + 1;
    localparam int RND_W    = R_W + RS_W;
    localparam int STATE_W  = 4 * NIBBLES;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef logic [TAG_W-1:0] tag_t;

    function automatic logic [3:0] nib(input logic [STATE_W-1:0] s, input tag_t i);
        return s[4*i +: 4];
    endfunction

endpackage

// File: rtl/midori_sbox_vpipe.sv
// {valid,tag} shift register that tracks nibbles inside the shared S-box.
// Advances every cycle because the S-box itself has no enable.
module midori_sbox_vpipe
    import midori_sbox_serial_ctrl_pkg::*;
#(
    parameter int DEPTH = SBOX_LAT,
    parameter int TW    = TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TW-1:0]    in_tag,
    output logic [DEPTH-1:0] valid,
    output logic [TW-1:0]    out_tag
);

    logic [DEPTH-1:0][TW-1:0] tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            tag   <= '0;
        end else begin
            valid <= {valid[DEPTH-2:0], in_valid};
            tag   <= {tag[DEPTH-2:0], in_tag};
        end
    end

    assign out_tag = tag[DEPTH-1];

endmodule

// File: rtl/midori_sbox_serial_ctrl.sv
// Streams 16 nibbles of a 3-share Midori state through one shared masked S-box
// and writes the returned shares back, chaining the S-box refresh input.
module midori_sbox_serial_ctrl
    import midori_sbox_serial_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in1,
    input  logic [STATE_W-1:0] state_in2,
    input  logic [STATE_W-1:0] state_in3,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state_out1,
    output logic [STATE_W-1:0] state_out2,
    output logic [STATE_W-1:0] state_out3,
    input  logic [RND_W-1:0]   rnd,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic               rnd_err,
    output logic [3:0]         sb_in1,
    output logic [3:0]         sb_in2,
    output logic [3:0]         sb_in3,
    output logic [R_W-1:0]     sb_r,
    output logic [RS_W-1:0]    sb_rs_in,
    input  logic [RS_W-1:0]    sb_rs_out,
    input  logic [3:0]         sb_out1,
    input  logic [3:0]         sb_out2,
    input  logic [3:0]         sb_out3
);

    state_t state, state_nxt;

    logic [CNT_W-1:0]    issue_cnt;
    logic [STATE_W-1:0]  sh1, sh2, sh3;
    logic [RS_W-1:0]     rs_fresh, rs_hold;
    logic                rs_hold_v;
    logic [SBOX_LAT-1:0] vp_valid;
    tag_t                cur_tag, wb_tag;
    logic                accept, issuing, inflight, drain_done;

    assign cur_tag    = issue_cnt[TAG_W-1:0];
    assign accept     = (state == IDLE) && start;
    assign issuing    = (state == RUN) && (issue_cnt < CNT_W'(NIBBLES)) && rnd_valid;
    assign inflight   = |vp_valid;
    // Last nibble only sits in the final stage: its writeback lands this cycle.
    assign drain_done = ~|vp_valid[SBOX_LAT-2:0];

    midori_sbox_vpipe #(
        .DEPTH (SBOX_LAT),
        .TW    (TAG_W)
    ) u_vpipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (issuing),
        .in_tag   (cur_tag),
        .valid    (vp_valid),
        .out_tag  (wb_tag)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        rnd_ready = rnd_valid && (issuing || inflight);
        sb_r      = '0;
        sb_in1    = '0;
        sb_in2    = '0;
        sb_in3    = '0;
        sb_rs_in  = '0;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issue_cnt == CNT_W'(NIBBLES)) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rnd_ready) sb_r = rnd[R_W-1:0];
        if (issuing) begin
            sb_in1 = nib(sh1, cur_tag);
            sb_in2 = nib(sh2, cur_tag);
            sb_in3 = nib(sh3, cur_tag);
        end
        // Feed the previous nibble's shares, never the current nibble's own.
        if (vp_valid[0]) sb_rs_in = rs_hold_v ? rs_hold : rs_fresh;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            sh1       <= '0;
            sh2       <= '0;
            sh3       <= '0;
            rs_fresh  <= '0;
            rnd_err   <= 1'b0;
        end else if (accept) begin
            issue_cnt <= '0;
            sh1       <= state_in1;
            sh2       <= state_in2;
            sh3       <= state_in3;
            rnd_err   <= 1'b0;
        end else begin
            if (issuing) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
                rs_fresh  <= rnd[RND_W-1:R_W];
            end
            if (!rnd_valid && inflight) rnd_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs_hold   <= '0;
            rs_hold_v <= 1'b0;
        end else begin
            rs_hold   <= sb_rs_out;
            rs_hold_v <= vp_valid[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            state_out1 <= '0;
            state_out2 <= '0;
            state_out3 <= '0;
        end else if (vp_valid[SBOX_LAT-1]) begin
            state_out1[4*wb_tag +: 4] <= sb_out1;
            state_out2[4*wb_tag +: 4] <= sb_out2;
            state_out3[4*wb_tag +: 4] <= sb_out3;
        end
    end

endmodule
